// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: iterative unsigned MULTU / MADDU engine with a private HI/LO pair.
// Shift-add over WIDTH iterations; busy stalls the pipeline while the engine runs.
// Optional build macro MULTU_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (results identical, latency data-dependent).
module multu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               op_q;
    logic [CW-1:0]      count;

    logic [2*WIDTH-1:0] add_term;
    logic [2*WIDTH-1:0] fin_value;
    logic               last_iter;
    logic               skip_run;

    // Stall request is a pure decode of the state register.
    assign busy = (state != IDLE);

    // Partial-product select, final HI/LO value and RUN exit condition.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        add_term  = '0;
        fin_value = acc;
        if (mplier[0]) begin
            add_term = mcand;
        end
        if (op_q) begin
            // Carry out of the top bit falls off the 2*WIDTH-bit sum (mod 2^(2W)).
            fin_value = {hi, lo} + acc;
        end
`ifdef MULTU_EARLY_TERM_EN
        last_iter = (count == CW'(1)) || (mplier[WIDTH-1:1] == '0);
        skip_run  = (b == '0);
`else
        last_iter = (count == CW'(1));
        skip_run  = 1'b0;
`endif
    end

    // Control FSM and datapath: issue, shift-add iterations, HI/LO write-back.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the operand/accumulator registers are reset too so a mid-run reset leaves no stale state visible.
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            op_q   <= 1'b0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        op_q   <= op;
                        count  <= CW'(WIDTH);
                        state  <= skip_run ? FIN : RUN;
                    end
                end
                RUN: begin
                    done   <= 1'b0;
                    acc    <= acc + add_term;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (last_iter) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    {hi, lo} <= fin_value;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed self-checking bench for multu_hilo_unit (WIDTH=32).
// Expected latencies follow the MULTU_EARLY_TERM_EN build macro when it is defined.
module tb_multu_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total  = 0;
    int          passed = 0;
    logic [63:0] model_hilo = '0;

    multu_hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Edges from issue to done for a given multiplier.
    function automatic int lat_of(input logic [31:0] mul);
`ifdef MULTU_EARLY_TERM_EN
        if (mul == 32'd0) return 1;
        for (int i = 31; i >= 0; i--) begin
            if (mul[i]) return i + 2;
        end
        return 1;
`else
        return 33;
`endif
    endfunction

    // Drive one request; returns #1 after the issue edge with start dropped.
    task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~op_i;
        a     = 32'hDEAD_BEEF;
        b     = 32'h5A5A_A5A5;
    endtask

    // Bounded wait for done; lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    // Issue one op and check latency, stall length, in-flight HI/LO and result.
    task automatic run_op(input string tag, input logic op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [63:0] exp_hilo);
        int lat;
        int bc;
        issue(op_i, a_i, b_i);
        check({tag, " busy@issue"}, {63'd0, busy}, 64'd1);
        check({tag, " hilo held"}, {hi, lo}, model_hilo);
        wait_done(lat, bc);
        check({tag, " latency"}, 64'(lat), 64'(lat_of(b_i)));
        check({tag, " busy cycles"}, 64'(bc), 64'(lat_of(b_i)));
        check({tag, " busy@done"}, {63'd0, busy}, 64'd0);
        check({tag, " result"}, {hi, lo}, exp_hilo);
        model_hilo = exp_hilo;
    endtask

    initial begin
        int done_cnt;
        int done_edge;
        int p1;
        int p2;

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state.
        #2;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Largest product, then MADDU issued in the done cycle.
        run_op("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue(1'b1, 32'd3, 32'd5);
        check("b2b done cleared", {63'd0, done}, 64'd0);
        check("b2b busy", {63'd0, busy}, 64'd1);
        begin
            int lat;
            int bc;
            wait_done(lat, bc);
            check("b2b latency", 64'(lat), 64'(lat_of(32'd5)));
            check("b2b result", {hi, lo}, 64'hFFFF_FFFE_0000_0010);
            model_hilo = 64'hFFFF_FFFE_0000_0010;
        end

        // Start pulses while busy are ignored; one done pulse only.
`ifdef MULTU_EARLY_TERM_EN
        p1 = 2;
        p2 = 4;
`else
        p1 = 5;
        p2 = 20;
`endif
        issue(1'b0, 32'd7, 32'd9);
        done_cnt  = 0;
        done_edge = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == p1 || i == p2) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 32'd2;
                b     = 32'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 3) check("ign hilo mid-run", {hi, lo}, 64'hFFFF_FFFE_0000_0010);
            if (done) begin
                done_cnt++;
                done_edge = i;
            end
        end
        check("ign done count", 64'(done_cnt), 64'd1);
        check("ign done edge", 64'(done_edge), 64'(lat_of(32'd9)));
        check("ign result", {hi, lo}, 64'd63);
        check("ign idle", {63'd0, busy}, 64'd0);

        // Reset mid-run abandons the operation.
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("mid rst busy", {63'd0, busy}, 64'd0);
        check("mid rst done", {63'd0, done}, 64'd0);
        check("mid rst hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("post rst no done", 64'(done_cnt), 64'd0);
        check("post rst hilo", {hi, lo}, 64'd0);
        model_hilo = '0;

        // Zero operands and b=1.
        run_op("multu a0", 1'b0, 32'd0, 32'd5, 64'd0);
        run_op("multu b1", 1'b0, 32'd1234, 32'd1, 64'd1234);
        run_op("maddu a0", 1'b1, 32'd0, 32'd7, 64'd1234);
        run_op("multu b0", 1'b0, 32'd5, 32'd0, 64'd0);

        // Accumulate up to all-ones, then wrap to zero.
        run_op("pre multu", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("pre maddu", 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("wrap maddu", 1'b1, 32'd1, 32'd1, 64'd0);

        // Multiplier with only the MSB set.
        run_op("multu msb", 1'b0, 32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
